// File: rtl/tx_rate_sched.sv
// Multi-rate clock-enable scheduler for the Tx chain: guard/run/drain sequencing with /2, /16, /32 strobes.
// Optional single-frame mode enabled by defining TX_SCHED_AUTOSTOP_EN.
module tx_rate_sched #(
    parameter int unsigned GUARD_CYC  = 4,
    parameter int unsigned FRAME_SYMS = 16,
    parameter int unsigned SYM_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             ce_2,
    output logic             ce_16,
    output logic             ce_32,
    output logic [4:0]       phase,
    output logic [SYM_W-1:0] sym_idx,
    output logic             frame_done
);

    localparam int unsigned PH_W    = 5;
    localparam int unsigned GUARD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    localparam logic [PH_W-1:0]    PH_LAST    = '1;
    localparam logic [SYM_W-1:0]   SYM_LAST   = SYM_W'(FRAME_SYMS - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [SYM_W-1:0]   sym_q, sym_d;

    logic busy_q, busy_d;
    logic ce_2_q, ce_2_d;
    logic ce_16_q, ce_16_d;
    logic ce_32_q, ce_32_d;
    logic frame_done_q, frame_done_d;

    logic sym_strobe;
    logic sym_last;
    logic end_run;
    logic run_d;

    // Next-state logic; strobe outputs are decoded from the next state so they register in step with phase.
    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        phase_d    = phase_q;
        sym_d      = sym_q;
        sym_strobe = (phase_q == PH_LAST);
        sym_last   = (sym_q == SYM_LAST);
        end_run    = 1'b0;

        case (state_q)
            S_IDLE: begin
                guard_d = '0;
                phase_d = '0;
                sym_d   = '0;
                if (start && !stop) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                phase_d = '0;
                sym_d   = '0;
                if (stop) begin
                    state_d = S_IDLE;
                    guard_d = '0;
                end else if (guard_q == GUARD_LAST) begin
                    state_d = S_RUN;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            S_RUN: begin
                if (stop) begin
                    if (sym_strobe) begin
                        end_run = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef TX_SCHED_AUTOSTOP_EN
                if (sym_strobe && sym_last) begin
                    end_run = 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (sym_strobe) begin
                    end_run = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
            phase_d = phase_q + PH_W'(1);
            if (sym_strobe) begin
                sym_d = sym_last ? '0 : sym_q + SYM_W'(1);
            end
        end

        // A run ending on the symbol boundary returns to a clean idle.
        if (end_run) begin
            state_d = S_IDLE;
            phase_d = '0;
            sym_d   = '0;
        end

        run_d        = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d       = (state_d != S_IDLE);
        ce_2_d       = run_d && phase_d[0];
        ce_16_d      = run_d && (phase_d[3:0] == 4'hF);
        ce_32_d      = run_d && (phase_d == PH_LAST);
        frame_done_d = ce_32_d && (sym_d == SYM_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            guard_q      <= '0;
            phase_q      <= '0;
            sym_q        <= '0;
            busy_q       <= 1'b0;
            ce_2_q       <= 1'b0;
            ce_16_q      <= 1'b0;
            ce_32_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            phase_q      <= phase_d;
            sym_q        <= sym_d;
            busy_q       <= busy_d;
            ce_2_q       <= ce_2_d;
            ce_16_q      <= ce_16_d;
            ce_32_q      <= ce_32_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign ce_2       = ce_2_q;
    assign ce_16      = ce_16_q;
    assign ce_32      = ce_32_q;
    assign phase      = phase_q;
    assign sym_idx    = sym_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tx_rate_sched.sv
// Scoreboard bench for tx_rate_sched: a cycle model pushes expected outputs, the DUT's outputs are popped and compared.
module tb_tx_rate_sched;

    localparam int GUARD_CYC  = 4;
    localparam int FRAME_SYMS = 16;
    localparam int SYM_W      = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    typedef struct packed {
        logic             busy;
        logic             ce_2;
        logic             ce_16;
        logic             ce_32;
        logic             frame_done;
        logic [4:0]       phase;
        logic [SYM_W-1:0] sym;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             ce_2;
    logic             ce_16;
    logic             ce_32;
    logic [4:0]       phase;
    logic [SYM_W-1:0] sym_idx;
    logic             frame_done;

    tx_rate_sched #(
        .GUARD_CYC (GUARD_CYC),
        .FRAME_SYMS(FRAME_SYMS),
        .SYM_W     (SYM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .ce_2      (ce_2),
        .ce_16     (ce_16),
        .ce_32     (ce_32),
        .phase     (phase),
        .sym_idx   (sym_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    int m_state = M_IDLE;
    int m_guard_left = 0;
    int m_phase = 0;
    int m_sym = 0;

    int cyc = 0;
    int t_start = 0;
    int first_ce2 = -1;
    int first_ce16 = -1;
    int first_ce32 = -1;
    int last_fd = -1;
    int ce2_since = 0;
    int ce32_total = 0;
    int fd_total = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance the reference model one clock with the given inputs.
    task automatic model_step(input logic st, input logic sp);
        bit strobe;
        bit last;
        bit done;
        strobe = (m_phase == 31);
        last   = strobe && (m_sym == FRAME_SYMS - 1);
        case (m_state)
            M_IDLE: begin
                if (st && !sp) begin
                    m_state      = M_ARM;
                    m_guard_left = GUARD_CYC;
                end
            end
            M_ARM: begin
                if (sp) m_state = M_IDLE;
                else if (m_guard_left == 1) m_state = M_RUN;
                else m_guard_left--;
            end
            default: begin
                done = (m_state == M_DRAIN && strobe) || (m_state == M_RUN && sp && strobe);
`ifdef TX_SCHED_AUTOSTOP_EN
                done = done || (m_state == M_RUN && last);
`endif
                if (done) begin
                    m_state = M_IDLE;
                    m_phase = 0;
                    m_sym   = 0;
                end else begin
                    m_phase = (m_phase + 1) % 32;
                    if (strobe) m_sym = last ? 0 : m_sym + 1;
                    if (m_state == M_RUN && sp) m_state = M_DRAIN;
                end
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   run;
        run          = (m_state == M_RUN) || (m_state == M_DRAIN);
        e.busy       = (m_state != M_IDLE);
        e.ce_2       = run && (m_phase % 2 == 1);
        e.ce_16      = run && (m_phase % 16 == 15);
        e.ce_32      = run && (m_phase == 31);
        e.frame_done = e.ce_32 && (m_sym == FRAME_SYMS - 1);
        e.phase      = 5'(m_phase);
        e.sym        = SYM_W'(m_sym);
        return e;
    endfunction

    // One clock: drive inputs, push model prediction, then compare at the falling edge.
    task automatic cycle(input logic st, input logic sp);
        exp_t e;
        start = st;
        stop  = sp;
        model_step(st, sp);
        sb_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("busy", 32'(busy), 32'(e.busy));
            check_val("ce_2", 32'(ce_2), 32'(e.ce_2));
            check_val("ce_16", 32'(ce_16), 32'(e.ce_16));
            check_val("ce_32", 32'(ce_32), 32'(e.ce_32));
            check_val("frame_done", 32'(frame_done), 32'(e.frame_done));
            check_val("phase", 32'(phase), 32'(e.phase));
            check_val("sym_idx", 32'(sym_idx), 32'(e.sym));
        end
        if (ce_2) ce2_since++;
        if (ce_2 && first_ce2 < 0) first_ce2 = cyc;
        if (ce_16 && first_ce16 < 0) first_ce16 = cyc;
        if (ce_32 && first_ce32 < 0) first_ce32 = cyc;
        if (ce_32) ce32_total++;
        if (frame_done) begin
            fd_total++;
            check_val("fd_phase", 32'(phase), 32'd31);
            check_val("fd_sym", 32'(sym_idx), 32'(FRAME_SYMS - 1));
            if (last_fd >= 0) begin
                check_val("fd_period", 32'(cyc - last_fd), 32'd512);
                check_val("ce2_per_frame", 32'(ce2_since), 32'd256);
            end
            last_fd   = cyc;
            ce2_since = 0;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_ce"}, 32'({ce_2, ce_16, ce_32, frame_done}), 32'd0);
        check_val({tag, "_phase"}, 32'(phase), 32'd0);
        check_val({tag, "_sym"}, 32'(sym_idx), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        check_quiet("rst_async");
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("rst_hold");
        end
        rst = 1'b1;
        m_state = M_IDLE;
        m_phase = 0;
        m_sym   = 0;
        sb_q.delete();
    endtask

    task automatic arm_markers();
        t_start    = cyc;
        first_ce2  = -1;
        first_ce16 = -1;
        first_ce32 = -1;
        last_fd    = -1;
        ce2_since  = 0;
        ce32_total = 0;
        fd_total   = 0;
    endtask

    task automatic wait_phase(input string tag, input int ph);
        int n = 0;
        while (phase != 5'(ph) && n < 64) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        check_val(tag, 32'(phase), 32'(ph));
    endtask

    task automatic run_until_idle(input string tag);
        int n = 0;
        while (busy && n < 64) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        check_val(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        do_reset(2);
        repeat (3) cycle(1'b0, 1'b0);

        arm_markers();
        cycle(1'b1, 1'b0);
`ifdef TX_SCHED_AUTOSTOP_EN
        repeat (600) cycle(1'b0, 1'b0);
        check_val("auto_ce32_cnt", 32'(ce32_total), 32'd16);
        check_val("auto_fd_cnt", 32'(fd_total), 32'd1);
        check_val("auto_idle", 32'(busy), 32'd0);
`else
        repeat (1100) cycle(1'b0, 1'b0);
        check_val("first_ce2", 32'(first_ce2 - t_start), 32'd6);
        check_val("first_ce16", 32'(first_ce16 - t_start), 32'd20);
        check_val("first_ce32", 32'(first_ce32 - t_start), 32'd36);
        check_val("fd_count", 32'(fd_total), 32'd2);

        // Stop mid-period drains to the symbol boundary.
        wait_phase("wait_ph10", 10);
        cycle(1'b0, 1'b1);
        run_until_idle("drain_idle");
        check_quiet("after_drain");
`endif

        // Stop landing on the boundary ends the run immediately.
        cycle(1'b1, 1'b0);
        wait_phase("wait_ph31", 31);
        cycle(1'b0, 1'b1);
        check_quiet("stop_at_31");

        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);

        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b0);

        // Reset asserted mid-run.
        cycle(1'b1, 1'b0);
        repeat (50) cycle(1'b0, 1'b0);
        do_reset(3);
        repeat (3) cycle(1'b0, 1'b0);
        check_quiet("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tx_rate_sched.md
Name: tx_rate_sched

Overview:
- Multi-rate clock-enable scheduler for the MIMO Tx chain.
- Replaces derived divided clocks with single-cycle enable strobes (/2, /16, /32) on the one `clk` domain.
- Sequences start-up (guard period), run, and graceful stop aligned to the /32 symbol boundary.
- Counts symbols per frame. Sits between the Tx top-level control and all slow-rate Tx datapath stages.

Parameters:
- GUARD_CYC, 4, number of cycles spent in ARM before RUN (≥1).
- FRAME_SYMS, 16, number of /32 symbol periods per frame (2..2^SYM_W).
- SYM_W, 4, width of the symbol index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin transmission
- stop  in  1  single-cycle request to end transmission
- busy  out  1  high whenever state ≠ IDLE
- ce_2  out  1  strobe, 1 cycle in every 2 during RUN/DRAIN
- ce_16  out  1  strobe, 1 cycle in every 16 during RUN/DRAIN
- ce_32  out  1  strobe, 1 cycle in every 32 during RUN/DRAIN (symbol strobe)
- phase  out  5  current position within the 32-cycle period
- sym_idx  out  SYM_W  index of the current symbol in the frame
- frame_done  out  1  single-cycle pulse on the last symbol strobe of a frame

Behaviour:
- Reset is asynchronous, active-low; clock is `clk`. On reset: state=IDLE and all counters are 0. All outputs are 0 (busy, ce_*, phase, sym_idx, frame_done).
- Every output is a function of registers only; no input-to-output combinational path.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - start=1 and stop=0 → ARM next cycle.
  - start and stop both 1 → stay IDLE.
- ARM:
  - Guard counter counts GUARD_CYC cycles, then → RUN.
  - phase and sym_idx are held at 0; all ce_* are 0.
  - stop=1 → IDLE next cycle.
  - start is ignored.
- RUN:
  - phase increments by 1 every cycle, modulo 32 (31→0 wrap).
  - The first RUN cycle has phase=0.
  - start is ignored.
- Strobe decode (RUN or DRAIN only):
  - ce_2 = phase[0]==1.
  - ce_16 = phase[3:0]==15.
  - ce_32 = phase==31.
  - Each strobe therefore marks the last cycle of its period.
- Symbol counting:
  - On each ce_32 cycle, sym_idx increments at the next edge.
  - When sym_idx==FRAME_SYMS-1 it wraps to 0 instead.
  - frame_done = ce_32 && sym_idx==FRAME_SYMS-1 (same cycle as the strobe).
- RUN with stop=1 → DRAIN.
  - Exception: if stop arrives in a cycle where phase==31, go directly to IDLE after that cycle. The ce_32 and any frame_done in that cycle are still emitted.
- DRAIN:
  - Identical to RUN (phase advances, strobes continue) until the cycle with phase==31.
  - That strobe cycle emits ce_32 (and frame_done if applicable), then → IDLE.
  - On return to IDLE, phase and sym_idx clear to 0.
  - start and stop are ignored in DRAIN.
- A partial frame is not completed on stop; sym_idx restarts at 0 on the next start.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No strobe is emitted during reset.

Optional Feature:
- Macro: TX_SCHED_AUTOSTOP_EN.
- Defined: single-frame mode. In RUN, the cycle asserting frame_done also ends the run; next state is IDLE, identical to a stop landing at that boundary. An explicit stop still works as described above.
- Not defined: RUN continues across frames indefinitely until stop; sym_idx wraps and frame_done pulses once per frame.

Test Plan:
- Reset with rst=0 for 3 cycles mid-RUN → all outputs 0 within the reset window; state IDLE; busy=0 after release.
- start pulse at cycle T (defaults) → busy=1 from T+1; ARM for cycles T+1..T+4; RUN begins T+5 with phase=0.
  - ce_2 first at T+6.
  - ce_16 first at T+20.
  - ce_32 first at T+36.
- Continuous RUN, defaults, macro off → frame_done every 512 cycles at phase=31, sym_idx=15; sym_idx then wraps to 0; exactly 256 ce_2 per frame.
- stop at RUN phase=10 → DRAIN; strobes continue; ce_32 at phase=31; IDLE next cycle with phase=0, sym_idx=0, busy=0.
- stop at phase=31 → ce_32 still emitted that cycle; IDLE next cycle. start+stop together in IDLE → remains IDLE. stop during ARM → IDLE next cycle with no strobes.
- TX_SCHED_AUTOSTOP_EN defined, single start → exactly 16 ce_32 pulses and one frame_done; busy drops the cycle after frame_done.
